// File: rtl/ecdsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecdsa_pkg
// Description : Shared widths, table-slot layout, fetch FSM encoding and
//               CSR byte offsets for the ECDSA operand path.
// Revision    : 1.0 - initial release
// ============================================================================
package ecdsa_pkg;

  localparam int DATA_W = 1024;
  localparam int ADDR_W = 17;
  localparam int SLOT_W = 32;
  localparam int ARGC_W = 6;

  // CSR byte offsets seen by the AXI-Lite front end
  localparam logic [7:0] CSR_COMMAND           = 8'h00;
  localparam logic [7:0] CSR_ADDR_TABLE_BASE_I = 8'h04;
  localparam logic [7:0] CSR_ARGC_I            = 8'h08;
  localparam logic [7:0] CSR_ADDR_TABLE_BASE_O = 8'h0C;
  localparam logic [7:0] CSR_ARGC_O            = 8'h10;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TBL_REQ  = 3'd1,
    ST_TBL_WAIT = 3'd2,
    ST_OP_REQ   = 3'd3,
    ST_OP_WAIT  = 3'd4,
    ST_OP_OUT   = 3'd5
  } fetch_state_e;

  // Slot 0 sits at the top of the table word; returns the LSB of slot i
  function automatic int slot_lsb(input int data_w, input int i);
    return data_w - SLOT_W * (i + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ecdsa_slot_mux.sv
`default_nettype none
// ============================================================================
// Module      : ecdsa_slot_mux
// Description : Combinational extract of the byte address held in table
//               slot [idx]. Upper slot bits beyond ADDR_W are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module ecdsa_slot_mux
  import ecdsa_pkg::*;
#(
  parameter int DATA_W = ecdsa_pkg::DATA_W,
  parameter int ADDR_W = ecdsa_pkg::ADDR_W,
  parameter int IDX_W  = 3
) (
  input  logic [DATA_W-1:0] tbl_word,
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] slot_addr
);

  localparam int NUM_SLOTS = 1 << IDX_W;

  logic [ADDR_W-1:0] slot_addrs [NUM_SLOTS];

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign slot_addrs[i] = tbl_word[slot_lsb(DATA_W, i) +: ADDR_W];
  end

  assign slot_addr = slot_addrs[idx];

  // Reserved slot bits and unused slots carry no meaning here
  logic unused_tbl_bits;
  assign unused_tbl_bits = ^tbl_word;

endmodule
`default_nettype wire

// File: rtl/ecdsa_arg_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ecdsa_arg_fetch
// Description : Reads the operand address table, then fetches each operand
//               from shared memory and streams it to the compute core.
// Revision    : 1.0 - initial release
// ============================================================================
module ecdsa_arg_fetch
  import ecdsa_pkg::*;
#(
  parameter int DATA_W   = ecdsa_pkg::DATA_W,
  parameter int ADDR_W   = ecdsa_pkg::ADDR_W,
  parameter int MAX_ARGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] tbl_base,
  input  logic [ARGC_W-1:0] argc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_data,
  output logic [IDX_W-1:0]  op_idx,
  output logic              op_last
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ARGC_W-1:0] argc_q, argc_d;
  logic [DATA_W-1:0] tbl_q, tbl_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] op_data_q, op_data_d;
  logic              op_valid_q, op_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] slot_addr;
  logic              is_last;

  ecdsa_slot_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_slot_mux (
    .tbl_word  (tbl_q),
    .idx       (idx_q),
    .slot_addr (slot_addr)
  );

  assign is_last = ({{(ARGC_W-IDX_W){1'b0}}, idx_q} == (argc_q - ARGC_W'(1)));

  // Next-state and datapath updates for the fetch sequencer
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    argc_d     = argc_q;
    tbl_d      = tbl_q;
    idx_d      = idx_q;
    op_data_d  = op_data_q;
    op_valid_d = op_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (argc == '0) begin
            done_d = 1'b1;
          end else if (argc > ARGC_W'(MAX_ARGS)) begin
            err_d = 1'b1;
          end else begin
            base_d  = tbl_base;
            argc_d  = argc;
            busy_d  = 1'b1;
            state_d = ST_TBL_REQ;
          end
        end
      end
      ST_TBL_REQ: begin
        if (mem_rd_gnt) state_d = ST_TBL_WAIT;
      end
      ST_TBL_WAIT: begin
        if (mem_rd_valid) begin
          tbl_d   = mem_rd_data;
          idx_d   = '0;
          state_d = ST_OP_REQ;
        end
      end
      ST_OP_REQ: begin
        if (mem_rd_gnt) state_d = ST_OP_WAIT;
      end
      ST_OP_WAIT: begin
        if (mem_rd_valid) begin
          op_data_d  = mem_rd_data;
          op_valid_d = 1'b1;
          state_d    = ST_OP_OUT;
        end
      end
      ST_OP_OUT: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          if (is_last) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_OP_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      argc_q     <= '0;
      tbl_q      <= '0;
      idx_q      <= '0;
      op_data_q  <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      argc_q     <= argc_d;
      tbl_q      <= tbl_d;
      idx_q      <= idx_d;
      op_data_q  <= op_data_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Memory request port: address is a pure function of state so it stays
  // stable for as long as the request is held
  always_comb begin
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    if (state_q == ST_TBL_REQ) begin
      mem_rd_req  = 1'b1;
      mem_rd_addr = base_q;
    end else if (state_q == ST_OP_REQ) begin
      mem_rd_req  = 1'b1;
      mem_rd_addr = slot_addr;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign op_valid = op_valid_q;
  assign op_data  = op_data_q;
  assign op_idx   = idx_q;
  assign op_last  = op_valid_q & is_last;

endmodule
`default_nettype wire
